// File: rtl/rc_filter_pkg.sv
// Shared constants, enums and the RC coefficient helper for the multichannel RC filter.
package rc_filter_pkg;

    localparam int Q_FRAC = 16;

    typedef enum logic {RC_HP = 1'b0, RC_LP = 1'b1} mode_e;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

    // HP uses RC/(RC+dt), LP uses dt/(RC+dt), both as 18-bit unsigned Q16.
    function automatic logic [17:0] rc_coef(input longint r, input longint c_35_shifted,
                                            input longint sample_rate, input int mode);
        longint rc_32;
        longint dt_32;
        longint num;
        rc_32 = (r * c_35_shifted) >>> 3;
        dt_32 = (longint'(1) << 32) / sample_rate;
        num   = (mode == 1) ? dt_32 : rc_32;
        return 18'((num << Q_FRAC) / (rc_32 + dt_32));
    endfunction

endpackage

// File: rtl/lfsr8.sv
// 8-bit maximal-length Fibonacci LFSR, advanced one step per request.
module lfsr8 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       step,
    output logic [7:0] value
);
    always_ff @(posedge clk) begin
        if (!rst_n)
            value <= 8'h01;
        else if (step)
            value <= {value[6:0], value[7] ^ value[5] ^ value[4] ^ value[3]};
    end
endmodule

// File: rtl/rc_filter_datapath.sv
// Two-stage channel-agnostic filter pipe: registered difference, then multiply/shift/saturate.
module rc_filter_datapath
    import rc_filter_pkg::*;
#(
    parameter int          DATA_W = 16,
    parameter int          IW     = 1,
    parameter mode_e       FMODE  = RC_HP,
    parameter logic [17:0] COEF   = 18'd0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     issue,
    input  logic [IW-1:0]            idx,
    input  logic signed [DATA_W-1:0] x,
    input  logic signed [DATA_W-1:0] y,
    input  logic signed [DATA_W:0]   x_prev,
    output logic                     res_vld,
    output logic [IW-1:0]            res_idx,
    output logic signed [DATA_W-1:0] res
);
    localparam int STAGES = 1;
    localparam int DW     = DATA_W + 2;
    localparam int PW     = DATA_W + 20;
    localparam int AW     = DATA_W + 4;
    localparam logic signed [AW-1:0] MAXV = AW'((64'sd1 <<< (DATA_W - 1)) - 64'sd1);
    localparam logic signed [AW-1:0] MINV = ~MAXV;

    logic [STAGES:1]          vld_pipe;
    logic signed [DW-1:0]     diff_c;
    logic signed [DW-1:0]     diff_q;
    logic signed [DATA_W-1:0] y_q;
    logic [IW-1:0]            idx_q;
    logic signed [PW-1:0]     prod;
    logic signed [AW-1:0]     acc;

    always_comb begin
        if (FMODE == RC_LP)
            diff_c = DW'(x) - DW'(y);
        else
            diff_c = DW'(y) + DW'(x) - DW'(x_prev);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            diff_q   <= '0;
            y_q      <= '0;
            idx_q    <= '0;
        end else begin
            vld_pipe <= issue;
            if (issue) begin
                diff_q <= diff_c;
                y_q    <= y;
                idx_q  <= idx;
            end
        end
    end

    // Coefficient is unsigned, so it gets a zero sign bit before the signed multiply.
    assign prod = PW'($signed({1'b0, COEF})) * PW'(diff_q);

    always_comb begin
        if (FMODE == RC_LP)
            acc = AW'(y_q) + AW'(prod >>> Q_FRAC);
        else
            acc = AW'(prod >>> Q_FRAC);
        if (acc > MAXV)
            res = MAXV[DATA_W-1:0];
        else if (acc < MINV)
            res = MINV[DATA_W-1:0];
        else
            res = acc[DATA_W-1:0];
    end

    assign res_vld = vld_pipe[STAGES];
    assign res_idx = idx_q;
endmodule

// File: rtl/rc_filter_multichannel.sv
// N-channel first-order RC filter; one shared multiplier walks the channels after each sample strobe.
module rc_filter_multichannel
    import rc_filter_pkg::*;
#(
    parameter int SAMPLE_RATE   = 48000,
    parameter int R             = 47000,
    parameter int C_35_SHIFTED  = 1615,
    parameter int CHANNELS      = 2,
    parameter int DATA_W        = 16,
    parameter int MODE          = 0,
    parameter int COEF_OVERRIDE = 0,
    parameter int DITHER        = 1
) (
    input  logic                         clk,
    input  logic                         I_RSTn,
    input  logic                         audio_clk_en,
    input  logic [CHANNELS*DATA_W-1:0]   in,
    output logic [CHANNELS*DATA_W-1:0]   out,
    output logic                         out_valid,
    output logic                         busy,
    output logic                         overrun
);
    localparam int          IW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam mode_e       FMODE = (MODE == 1) ? RC_LP : RC_HP;
    localparam logic [17:0] COEF  = (COEF_OVERRIDE != 0) ? 18'(COEF_OVERRIDE)
                                  : rc_coef(R, C_35_SHIFTED, SAMPLE_RATE, MODE);

    state_e                   state;
    logic [IW-1:0]            ch;
    logic signed [DATA_W-1:0] snap   [CHANNELS];
    logic signed [DATA_W-1:0] y      [CHANNELS];
    logic signed [DATA_W:0]   x_prev [CHANNELS];
    logic [7:0]               lfsr_q;
    logic signed [DATA_W:0]   dith;
    logic                     accept;
    logic                     res_vld;
    logic [IW-1:0]            res_idx;
    logic signed [DATA_W-1:0] res;

    assign accept = audio_clk_en && !busy;

    lfsr8 u_lfsr (
        .clk   (clk),
        .rst_n (I_RSTn),
        .step  (accept),
        .value (lfsr_q)
    );

    // Top two LFSR bits minus 2 give a dither of -2..+1, shared by every channel of a sample.
    assign dith = (DITHER != 0 && FMODE == RC_HP)
                ? (DATA_W+1)'($signed({1'b0, lfsr_q[7:6]}) - 3'sd2) : '0;

    rc_filter_datapath #(
        .DATA_W (DATA_W),
        .IW     (IW),
        .FMODE  (FMODE),
        .COEF   (COEF)
    ) u_dp (
        .clk     (clk),
        .rst_n   (I_RSTn),
        .issue   (state == S_RUN),
        .idx     (ch),
        .x       (snap[ch]),
        .y       (y[ch]),
        .x_prev  (x_prev[ch]),
        .res_vld (res_vld),
        .res_idx (res_idx),
        .res     (res)
    );

    always_ff @(posedge clk) begin
        if (!I_RSTn) begin
            state     <= S_IDLE;
            ch        <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
            out       <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                snap[c]   <= '0;
                y[c]      <= '0;
                x_prev[c] <= '0;
            end
        end else begin
            out_valid <= 1'b0;
            if (audio_clk_en && busy)
                overrun <= 1'b1;
            if (res_vld)
                y[res_idx] <= res;
            case (state)
                S_IDLE: begin
                    if (audio_clk_en) begin
                        for (int c = 0; c < CHANNELS; c++)
                            snap[c] <= in[c*DATA_W +: DATA_W];
                        busy  <= 1'b1;
                        ch    <= '0;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    x_prev[ch] <= (DATA_W+1)'(snap[ch]) + dith;
                    if (ch == IW'(CHANNELS - 1))
                        state <= S_DONE;
                    else
                        ch <= ch + IW'(1);
                end
                S_DONE: begin
                    // Wait for the final channel to leave the multiplier stage.
                    if (!res_vld) begin
                        for (int c = 0; c < CHANNELS; c++)
                            out[c*DATA_W +: DATA_W] <= y[c];
                        out_valid <= 1'b1;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rc_filter_multichannel.sv
// Bench: four filter configurations driven in lockstep against an arithmetic reference model.
module tb_rc_filter_multichannel;
    localparam longint ALPHA = 64923;
    localparam longint BETA  = 612;
    localparam longint OVC   = 98304;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [31:0] hp_in = '0, lp_in = '0, ov_in = '0;
    logic [63:0] q4_in = '0;
    logic [31:0] hp_out, lp_out, ov_out;
    logic [63:0] q4_out;
    logic        hp_valid, hp_busy, hp_ovr;
    logic        lp_valid, lp_busy, lp_ovr;
    logic        ov_valid, ov_busy, ov_ovr;
    logic        q4_valid, q4_busy, q4_ovr;

    int errs = 0;
    int checks = 0;

    longint m_hp_y[2], m_hp_xp[2], m_lp_y[2], m_ov_y[2], m_ov_xp[2], m_q4_y[4], m_q4_xp[4];

    always #5 clk = ~clk;

    rc_filter_multichannel #(.CHANNELS(2), .MODE(0), .DITHER(0)) u_hp (
        .clk(clk), .I_RSTn(rst_n), .audio_clk_en(en), .in(hp_in),
        .out(hp_out), .out_valid(hp_valid), .busy(hp_busy), .overrun(hp_ovr));
    rc_filter_multichannel #(.CHANNELS(2), .MODE(1)) u_lp (
        .clk(clk), .I_RSTn(rst_n), .audio_clk_en(en), .in(lp_in),
        .out(lp_out), .out_valid(lp_valid), .busy(lp_busy), .overrun(lp_ovr));
    rc_filter_multichannel #(.CHANNELS(2), .MODE(0), .DITHER(0), .COEF_OVERRIDE(98304)) u_ov (
        .clk(clk), .I_RSTn(rst_n), .audio_clk_en(en), .in(ov_in),
        .out(ov_out), .out_valid(ov_valid), .busy(ov_busy), .overrun(ov_ovr));
    rc_filter_multichannel #(.CHANNELS(4), .MODE(0), .DITHER(0)) u_q4 (
        .clk(clk), .I_RSTn(rst_n), .audio_clk_en(en), .in(q4_in),
        .out(q4_out), .out_valid(q4_valid), .busy(q4_busy), .overrun(q4_ovr));

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic longint lane(input logic [63:0] v, input int c);
        logic signed [15:0] s;
        s = v[c*16 +: 16];
        return longint'(s);
    endfunction

    function automatic longint sat16(input longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic longint hp_f(input longint a, input longint y, input longint x, input longint xp);
        return sat16((a * (y + x - xp)) >>> 16);
    endfunction

    function automatic longint lp_f(input longint b, input longint y, input longint x);
        return sat16(y + ((b * (x - y)) >>> 16));
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            m_hp_y[c] = 0; m_hp_xp[c] = 0; m_lp_y[c] = 0; m_ov_y[c] = 0; m_ov_xp[c] = 0;
        end
        for (int c = 0; c < 4; c++) begin
            m_q4_y[c] = 0; m_q4_xp[c] = 0;
        end
    endtask

    task automatic model_and_check(input logic [31:0] hi, input logic [31:0] li,
                                   input logic [31:0] oi, input logic [63:0] qi);
        longint x;
        for (int c = 0; c < 2; c++) begin
            x = lane({32'b0, hi}, c);
            m_hp_y[c] = hp_f(ALPHA, m_hp_y[c], x, m_hp_xp[c]);
            m_hp_xp[c] = x;
            chk($sformatf("hp_ch%0d", c), lane({32'b0, hp_out}, c), m_hp_y[c]);
            x = lane({32'b0, li}, c);
            m_lp_y[c] = lp_f(BETA, m_lp_y[c], x);
            chk($sformatf("lp_ch%0d", c), lane({32'b0, lp_out}, c), m_lp_y[c]);
            x = lane({32'b0, oi}, c);
            m_ov_y[c] = hp_f(OVC, m_ov_y[c], x, m_ov_xp[c]);
            m_ov_xp[c] = x;
            chk($sformatf("ov_ch%0d", c), lane({32'b0, ov_out}, c), m_ov_y[c]);
        end
        for (int c = 0; c < 4; c++) begin
            x = lane(qi, c);
            m_q4_y[c] = hp_f(ALPHA, m_q4_y[c], x, m_q4_xp[c]);
            m_q4_xp[c] = x;
            chk($sformatf("q4_ch%0d", c), lane(q4_out, c), m_q4_y[c]);
        end
    endtask

    // One strobe plus 7 observed cycles; inputs are scrambled after E0, dbl adds a strobe at E0+3.
    task automatic run_sample(input bit dbl);
        logic [63:0] q4_prev;
        int hp_at, q4_at, hp_n, q4_n;
        bit busy_ok, stable_ok;
        q4_prev = q4_out;
        hp_at = -1; q4_at = -1; hp_n = 0; q4_n = 0; busy_ok = 1'b1; stable_ok = 1'b1;
        en = 1'b1;
        @(posedge clk); #1;
        en = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            en = dbl && (k == 2);
            if (k == 1) begin
                hp_in = $urandom; lp_in = $urandom; ov_in = $urandom; q4_in = {$urandom, $urandom};
            end
            if (hp_valid) begin hp_n++; hp_at = k; end
            if (q4_valid) begin q4_n++; q4_at = k; q4_prev = q4_out; end
            else if (q4_out != q4_prev) stable_ok = 1'b0;
            if (q4_busy != (k < 6)) busy_ok = 1'b0;
            if (hp_busy != (k < 4)) busy_ok = 1'b0;
        end
        en = 1'b0;
        chk("hp_valid_at", hp_at, 4);
        chk("hp_valid_cnt", hp_n, 1);
        chk("q4_valid_at", q4_at, 6);
        chk("q4_valid_cnt", q4_n, 1);
        chk("busy_window", busy_ok, 1);
        chk("q4_out_stable", stable_ok, 1);
    endtask

    typedef struct {
        logic [31:0] hin;
        longint      e0;
        longint      e1;
    } vec_t;

    initial begin
        vec_t vt[5];
        logic [31:0] hi, li, oi;
        logic [63:0] qi;
        longint lp_prev;
        int vcnt;

        vt[0] = '{{16'(-10000), 16'(10000)},  9906,   -9907};
        vt[1] = '{{16'(-10000), 16'(10000)},  9813,   -9815};
        vt[2] = '{{16'(0),      16'(0)},      -186,   183};
        vt[3] = '{{16'(-32768), 16'(32767)},  32276,  -32281};
        vt[4] = '{{16'(32767),  16'(-32768)}, -32768, 32767};

        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hp_out", hp_out, 0);
        chk("rst_q4_out", q4_out, 0);
        chk("rst_valid", {hp_valid, lp_valid, ov_valid, q4_valid}, 0);
        chk("rst_busy", {hp_busy, lp_busy, ov_busy, q4_busy}, 0);
        chk("rst_overrun", {hp_ovr, lp_ovr, ov_ovr, q4_ovr}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        lp_prev = 0;
        for (int i = 0; i < 5; i++) begin
            hi = vt[i].hin;
            li = {16'($urandom), 16'(10000)};
            oi = {16'($urandom), (i == 0) ? 16'(20000) : (i == 1) ? 16'(30000) : 16'($urandom)};
            qi = {$urandom, $urandom};
            hp_in = hi; lp_in = li; ov_in = oi; q4_in = qi;
            run_sample(1'b0);
            chk($sformatf("vec%0d_ch0", i), lane({32'b0, hp_out}, 0), vt[i].e0);
            chk($sformatf("vec%0d_ch1", i), lane({32'b0, hp_out}, 1), vt[i].e1);
            if (i == 0) begin
                chk("lp_first", lane({32'b0, lp_out}, 0), 93);
                chk("ov_gain", lane({32'b0, ov_out}, 0), 30000);
            end
            if (i == 1) chk("ov_sat", lane({32'b0, ov_out}, 0), 32767);
            chk("lp_rise", lane({32'b0, lp_out}, 0) > lp_prev && lane({32'b0, lp_out}, 0) <= 10000, 1);
            lp_prev = lane({32'b0, lp_out}, 0);
            model_and_check(hi, li, oi, qi);
        end

        for (int i = 0; i < 20; i++) begin
            hi = $urandom; li = $urandom; oi = $urandom; qi = {$urandom, $urandom};
            hp_in = hi; lp_in = li; ov_in = oi; q4_in = qi;
            run_sample(1'b0);
            model_and_check(hi, li, oi, qi);
        end
        chk("no_overrun", {hp_ovr, lp_ovr, ov_ovr, q4_ovr}, 0);

        hi = $urandom; li = $urandom; oi = $urandom; qi = {$urandom, $urandom};
        hp_in = hi; lp_in = li; ov_in = oi; q4_in = qi;
        run_sample(1'b1);
        model_and_check(hi, li, oi, qi);
        chk("overrun_set", {hp_ovr, lp_ovr, ov_ovr, q4_ovr}, 4'hF);

        hp_in = $urandom; q4_in = {$urandom, $urandom};
        en = 1'b1;
        @(posedge clk); #1;
        en = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("mid_rst_out", {hp_out, lp_out, ov_out} | 96'(q4_out), 0);
        chk("mid_rst_flags", {hp_valid, hp_busy, hp_ovr, q4_valid, q4_busy, q4_ovr}, 0);
        vcnt = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            vcnt += int'(hp_valid) + int'(q4_valid) + int'(hp_busy) + int'(q4_busy);
        end
        chk("mid_rst_quiet", vcnt, 0);
        model_reset();

        hi = vt[0].hin; li = $urandom; oi = $urandom; qi = {$urandom, $urandom};
        hp_in = hi; lp_in = li; ov_in = oi; q4_in = qi;
        run_sample(1'b0);
        chk("post_rst_ch0", lane({32'b0, hp_out}, 0), 9906);
        chk("post_rst_ch1", lane({32'b0, hp_out}, 1), -9907);
        model_and_check(hi, li, oi, qi);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
